mem_access_unit: RTL and testbench

Parametrised MEM stage of the MIPS pipeline, sitting between the EX/MEM and MEM/WB boundaries.

- Replaces the single-cycle word-only stage with a load/store unit that:
  - supports byte/halfword/word access with sign or zero extension;
  - drives a request/grant/response data-memory port with wait states;
  - stalls the upstream pipe while an access is outstanding;
  - flags misaligned accesses and response timeouts.
- Registered outputs feed WB exactly as the old MEM/WB register did.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/ls_align.sv | 50 +++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and byte-lane enable patterns.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  // Size 2'b11 falls into the word case, so it is checked like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ls_align.sv
// Combinational lane logic: store byte enables / data replication, load lane
// extraction with sign or zero extension, and the misalignment flag.
module ls_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign misaligned = is_misaligned(size, off);

  // Replicating the datum across the word lets the memory pick any lane via be.
  always_comb begin
    be    = LANE_W;
    wdata = st_data;
    case (size)
      SZ_B: begin
        be    = LANE_B << off;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be    = LANE_H << off;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (size)
      SZ_B:    ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: byte/half/word load-store unit on a req/gnt/rvalid data port,
// stalling upstream while an access is outstanding, feeding the MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int REG_W    = 5,
  parameter int WB_W     = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [WB_W-1:0]   ex_wb,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              fwd_sel,
  input  logic [31:0]       fwd_data,
  output logic              stall_out,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic [WB_W-1:0]   wb_ctl,
  output logic [REG_W-1:0]  wb_rd,
  output logic [31:0]       wb_alu,
  output logic [31:0]       wb_load,
  output logic              misalign,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic        mem_op, misaligned, access, misalign_op;
  logic        timeout, resp_done;
  logic [31:0] st_data, lane_wdata, ld_data;
  logic [3:0]  lane_be;

  assign st_data = fwd_sel ? fwd_data : ex_wdata;

  ls_align u_align (
    .size        (ex_size),
    .ld_unsigned (ex_unsigned),
    .off         (ex_addr[1:0]),
    .st_data     (st_data),
    .rdata       (dm_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .ld_data     (ld_data),
    .misaligned  (misaligned)
  );

  assign mem_op      = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misalign_op = mem_op & misaligned;
  assign access      = mem_op & ~misaligned;

  // The counter holds the number of RESP cycles already spent without data,
  // so the timeout fires in the MAX_WAIT-th RESP cycle.
  assign timeout   = (state == RESP) & ~dm_rvalid & (cnt >= CNT_LAST);
  assign resp_done = (state == RESP) & dm_rvalid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (dm_req & dm_gnt & ~ex_mem_wr) state_nx = RESP;
      RESP: if (dm_rvalid | timeout)          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != RESP) cnt <= '0;
    else if (cnt != CNT_MAX)    cnt <= cnt + 1'b1;
  end

  always_comb begin
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_be     = '0;
    dm_wdata  = '0;
    stall_out = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: if (access) begin
          dm_req    = 1'b1;
          dm_we     = ex_mem_wr;
          dm_addr   = ex_addr[ADDR_W+1:2];
          dm_be     = lane_be;
          dm_wdata  = ex_mem_wr ? lane_wdata : '0;
          stall_out = ~(dm_gnt & ex_mem_wr);
        end
        RESP: stall_out = ~dm_rvalid & ~timeout;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_ctl   <= '0;
      wb_rd    <= '0;
      wb_alu   <= '0;
      wb_load  <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else if (stall_out) begin
      wb_valid <= 1'b0;
      wb_ctl   <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      wb_ctl   <= (ex_valid & ~misalign_op & ~timeout) ? ex_wb : '0;
      wb_rd    <= ex_rd;
      wb_alu   <= ex_addr;
      wb_load  <= resp_done ? ld_data : '0;
      misalign <= misalign_op;
      bus_err  <= timeout;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboard of expected MEM/WB slots,
// one task per scenario, with MAX_WAIT reduced to 3 to exercise the timeout.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int ADDR_W   = 13;
  localparam int REG_W    = 5;
  localparam int WB_W     = 2;
  localparam int MAX_WAIT = 3;

  logic              clk, reset;
  logic              ex_valid, ex_mem_rd, ex_mem_wr, ex_unsigned, fwd_sel;
  logic [WB_W-1:0]   ex_wb;
  logic [REG_W-1:0]  ex_rd;
  logic [1:0]        ex_size;
  logic [31:0]       ex_addr, ex_wdata, fwd_data;
  logic              stall_out, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata, dm_rdata;
  logic              wb_valid, misalign, bus_err;
  logic [WB_W-1:0]   wb_ctl;
  logic [REG_W-1:0]  wb_rd;
  logic [31:0]       wb_alu, wb_load;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  ctl;
    logic [REG_W-1:0] rd;
    logic [31:0]      alu;
    logic [31:0]      load;
    logic             mis;
    logic             berr;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .REG_W(REG_W), .WB_W(WB_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_rd(ex_rd),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall_out(stall_out),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_ctl(wb_ctl), .wb_rd(wb_rd), .wb_alu(wb_alu),
    .wb_load(wb_load), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic wb_t wb_now();
    return '{wb_valid, wb_ctl, wb_rd, wb_alu, wb_load, misalign, bus_err};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (size)
      2'b00:   return uns ? (sh & 32'hFF)   : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_wb = '0; ex_rd = '0; ex_mem_rd = 0; ex_mem_wr = 0;
    ex_size = SZ_W; ex_unsigned = 0; ex_addr = '0; ex_wdata = '0;
    fwd_sel = 0; fwd_data = '0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
  endtask

  task automatic set_op(input logic v, input logic [WB_W-1:0] wb, input logic [REG_W-1:0] rd,
                        input logic rd_en, input logic wr_en, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic fsel, input logic [31:0] fdata);
    ex_valid = v; ex_wb = wb; ex_rd = rd; ex_mem_rd = rd_en; ex_mem_wr = wr_en;
    ex_size = size; ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata;
    fwd_sel = fsel; fwd_data = fdata; dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
  endtask

  task automatic do_store(input string name, input logic [WB_W-1:0] wb, input logic [REG_W-1:0] rd,
                          input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic fsel, input logic [31:0] fdata, input int gnt_delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int  stalls = 0;
    bit  done = 0;
    bit  req_ok = 1;
    wb_t e;
    set_op(1, wb, rd, 0, 1, size, 0, addr, wdata, fsel, fdata);
    exp_q.push_back('{1'b1, wb, rd, addr, 32'h0, 1'b0, 1'b0});
    for (int c = 0; c < 20 && !done; c++) begin
      dm_gnt = (c == gnt_delay);
      @(negedge clk);
      if (stall_out) stalls++;
      if (!dm_req || !dm_we || dm_addr !== addr[ADDR_W+1:2]) req_ok = 0;
      if (dm_gnt) begin
        n_cmp++;
        if (dm_be !== exp_be || dm_wdata !== exp_wdata) begin
          n_bad++;
          $display("FAIL %s_lanes: got be=%b data=%h, need be=%b data=%h",
                   name, dm_be, dm_wdata, exp_be, exp_wdata);
        end
      end
      tick();
      if (wb_valid) begin
        done = 1;
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_now() !== e) begin
          n_bad++;
          $display("FAIL %s_wb: got %h, need %h", name, wb_now(), e);
        end
      end
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_done: got no wb_valid, need completion", name); end
    n_cmp++;
    if (stalls != gnt_delay) begin n_bad++; $display("FAIL %s_stall: got %0d, need %0d", name, stalls, gnt_delay); end
    n_cmp++;
    if (!req_ok) begin n_bad++; $display("FAIL %s_req: got bad dm_req/we/addr, need store request addr %h", name, addr[ADDR_W+1:2]); end
  endtask

  // rv_cyc < 0 means rvalid never comes; early_rv also pulses rvalid with gnt.
  task automatic do_load(input string name, input logic [WB_W-1:0] wb, input logic [REG_W-1:0] rd,
                         input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] rdata, input int rv_cyc, input bit early_rv,
                         input int exp_stall, input wb_t e_in);
    int  stalls = 0;
    bit  done = 0;
    bit  req_ok = 1;
    wb_t e;
    set_op(1, wb, rd, 1, 0, size, uns, addr, 32'h0BAD0BAD, 0, 32'h0);
    exp_q.push_back(e_in);
    for (int c = 0; c < 20 && !done; c++) begin
      dm_gnt    = (c == 0);
      dm_rvalid = (c == rv_cyc) || (early_rv && c == 0);
      dm_rdata  = (c == rv_cyc) ? rdata : 32'h7E7E_7E7E;
      @(negedge clk);
      if (stall_out) stalls++;
      if (c == 0 && (!dm_req || dm_we || dm_addr !== addr[ADDR_W+1:2])) req_ok = 0;
      if (c > 0 && dm_req) req_ok = 0;
      tick();
      if (wb_valid) begin
        done = 1;
        e = exp_q.pop_front();
        n_cmp++;
        if (wb_now() !== e) begin
          n_bad++;
          $display("FAIL %s_wb: got %h, need %h", name, wb_now(), e);
        end
      end
    end
    dm_rvalid = 0;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_done: got no wb_valid, need completion", name); end
    n_cmp++;
    if (stalls != exp_stall) begin n_bad++; $display("FAIL %s_stall: got %0d, need %0d", name, stalls, exp_stall); end
    n_cmp++;
    if (!req_ok) begin n_bad++; $display("FAIL %s_req: got bad dm_req sequence, need single load request", name); end
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    ex_valid = 1; ex_mem_rd = 1; ex_addr = 32'h10; dm_gnt = 1;
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_dm: got req=%b we=%b addr=%h stall=%b, need all 0", dm_req, dm_we, dm_addr, stall_out);
    end
    tick();
    n_cmp++;
    if (wb_now() !== '0) begin n_bad++; $display("FAIL reset_wb: got %h, need 0", wb_now()); end
    reset = 0;
    set_idle();
    tick();
  endtask

  task automatic test_alu_op();
    wb_t e;
    logic [31:0] addrs [3] = '{32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0003};
    for (int i = 0; i < 3; i++) begin
      set_op(1, WB_W'(i + 1), REG_W'(7 + i), 0, 0, SZ_W, 0, addrs[i], 32'h0, 0, 32'h0);
      exp_q.push_back('{1'b1, WB_W'(i + 1), REG_W'(7 + i), addrs[i], 32'h0, 1'b0, 1'b0});
      @(negedge clk);
      n_cmp++;
      if (stall_out || dm_req) begin n_bad++; $display("FAIL alu_stall: got stall=%b req=%b, need 0 0", stall_out, dm_req); end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (wb_now() !== e) begin n_bad++; $display("FAIL alu_wb: got %h, need %h", wb_now(), e); end
    end
    set_op(0, 2'b11, 5'd9, 1, 0, SZ_W, 0, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (dm_req) begin n_bad++; $display("FAIL bubble_req: got %b, need 0", dm_req); end
    tick();
    n_cmp++;
    if ({wb_valid, wb_ctl} !== '0) begin n_bad++; $display("FAIL bubble_wb: got valid=%b ctl=%b, need 0 0", wb_valid, wb_ctl); end
  endtask

  task automatic test_stores();
    do_store("sw_fwd", 2'b10, 5'd0, SZ_W, 32'h10, 32'h1111_1111, 1, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
    do_store("sh_wait", 2'b10, 5'd0, SZ_H, 32'h2, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 1, 4'b1100, 32'hABCD_ABCD);
    do_store("sb_wait", 2'b01, 5'd0, SZ_B, 32'h1, 32'h0000_005A, 0, 32'hFFFF_FFFF, 2, 4'b0010, 32'h5A5A_5A5A);
    do_store("sb_hi", 2'b01, 5'd0, SZ_B, 32'h7, 32'h0, 1, 32'h0000_00C3, 0, 4'b1000, 32'hC3C3_C3C3);
  endtask

  task automatic test_loads();
    do_load("lb",  2'b11, 5'd4, SZ_B, 0, 32'h13, 32'h80FF_0000, 2, 0, 2, '{1'b1, 2'b11, 5'd4, 32'h13, 32'hFFFF_FF80, 1'b0, 1'b0});
    do_load("lbu", 2'b11, 5'd5, SZ_B, 1, 32'h13, 32'h80FF_0000, 2, 0, 2, '{1'b1, 2'b11, 5'd5, 32'h13, 32'h0000_0080, 1'b0, 1'b0});
    do_load("lhu", 2'b01, 5'd6, SZ_H, 1, 32'h2,  32'h8001_7FFF, 1, 0, 1, '{1'b1, 2'b01, 5'd6, 32'h2, 32'h0000_8001, 1'b0, 1'b0});
    do_load("lw",  2'b01, 5'd7, SZ_W, 1, 32'h8,  32'hCAFE_F00D, 3, 0, 3, '{1'b1, 2'b01, 5'd7, 32'h8, 32'hCAFE_F00D, 1'b0, 1'b0});
    do_load("l11", 2'b01, 5'd8, 2'b11, 0, 32'hC, 32'h8765_4321, 1, 0, 1, '{1'b1, 2'b01, 5'd8, 32'hC, 32'h8765_4321, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  sz, off;
      logic        uns;
      logic [31:0] addr, rdata;
      int          k;
      sz    = 2'($urandom_range(0, 2));
      uns   = 1'($urandom_range(0, 1));
      off   = (sz == SZ_B) ? 2'($urandom_range(0, 3)) : (sz == SZ_H) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      addr  = {$urandom_range(0, 32'hFFFF), 14'h0, off};
      rdata = $urandom;
      k     = $urandom_range(1, MAX_WAIT);
      do_load("lrand", 2'b11, REG_W'(i + 10), sz, uns, addr, rdata, k, 0, k,
              '{1'b1, 2'b11, REG_W'(i + 10), addr, model_load(sz, uns, off, rdata), 1'b0, 1'b0});
    end
  endtask

  task automatic test_gnt_rvalid_same();
    do_load("early_rv", 2'b11, 5'd3, SZ_H, 0, 32'h2, 32'h8001_7FFF, 1, 1, 1,
            '{1'b1, 2'b11, 5'd3, 32'h2, 32'hFFFF_8001, 1'b0, 1'b0});
  endtask

  task automatic test_misalign();
    wb_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_op(1, 2'b11, 5'd9, 1, 0, SZ_W, 0, 32'h6, 32'h0, 0, 32'h0);
      else        set_op(1, 2'b10, 5'd2, 0, 1, SZ_H, 0, 32'h5, 32'h1234, 0, 32'h0);
      dm_gnt = 1;
      exp_q.push_back('{1'b1, 2'b00, ex_rd, ex_addr, 32'h0, 1'b1, 1'b0});
      @(negedge clk);
      n_cmp++;
      if (dm_req || stall_out) begin n_bad++; $display("FAIL misalign_req: got req=%b stall=%b, need 0 0", dm_req, stall_out); end
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (wb_now() !== e) begin n_bad++; $display("FAIL misalign_wb: got %h, need %h", wb_now(), e); end
      set_idle();
      tick();
      n_cmp++;
      if (misalign !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: got %b, need 0", misalign); end
    end
  endtask

  task automatic test_timeout();
    do_load("timeout", 2'b11, 5'd12, SZ_W, 0, 32'h20, 32'h0, -1, 0, MAX_WAIT,
            '{1'b1, 2'b00, 5'd12, 32'h20, 32'h0, 1'b0, 1'b1});
    set_idle();
    tick();
    n_cmp++;
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL bus_err_pulse: got %b, need 0", bus_err); end
  endtask

  task automatic test_reset_mid_resp();
    wb_t e;
    set_op(1, 2'b11, 5'd13, 1, 0, SZ_W, 0, 32'h30, 32'h0, 0, 32'h0);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    reset = 1;
    @(negedge clk);
    n_cmp++;
    if (stall_out || dm_req) begin n_bad++; $display("FAIL rst_resp_comb: got stall=%b req=%b, need 0 0", stall_out, dm_req); end
    tick();
    n_cmp++;
    if (wb_now() !== '0) begin n_bad++; $display("FAIL rst_resp_wb: got %h, need 0", wb_now()); end
    reset = 0;
    set_op(1, 2'b01, 5'd3, 0, 0, SZ_W, 0, 32'h99, 32'h0, 0, 32'h0);
    dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF;
    exp_q.push_back('{1'b1, 2'b01, 5'd3, 32'h99, 32'h0, 1'b0, 1'b0});
    @(negedge clk);
    n_cmp++;
    if (stall_out || dm_req) begin n_bad++; $display("FAIL stray_rv_comb: got stall=%b req=%b, need 0 0", stall_out, dm_req); end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (wb_now() !== e) begin n_bad++; $display("FAIL stray_rv_wb: got %h, need %h", wb_now(), e); end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    do_store("b2b_sw", 2'b00, 5'd0, SZ_W, 32'h40, 32'h0102_0304, 0, 32'h0, 0, 4'b1111, 32'h0102_0304);
    do_load("b2b_lbu", 2'b11, 5'd14, SZ_B, 1, 32'h41, 32'h0000_C300, 1, 0, 1,
            '{1'b1, 2'b11, 5'd14, 32'h41, 32'h0000_00C3, 1'b0, 1'b0});
    set_idle();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d entries, need 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_alu_op();
    test_stores();
    test_loads();
    test_gnt_rvalid_same();
    test_misalign();
    test_timeout();
    test_reset_mid_resp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
